// File: rtl/dz_scan_ctrl.sv
// Bicolour dot-matrix row scanner with a double-buffered red/green
// frame store, tear-free swap at frame boundaries, blink and row dwell.
module dz_scan_ctrl #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int DWELL          = 1,
  parameter int BLINK_FRAMES   = 64,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_red,
  input  logic [COLS-1:0] wr_grn,
  input  logic            swap,
  input  logic            blink_en,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] colr,
  output logic [COLS-1:0] colg,
  output logic            frame_start,
  output logic            swap_done,
  output logic            swap_pending
);

  localparam int DW = $clog2(DWELL + 1);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [RW:0]   ROWS_W     = (RW+1)'(ROWS);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [ROWS-1:0] ROW_IDLE =
    ROW_ACTIVE_LOW ? {ROWS{1'b1}} : {ROWS{1'b0}};

  logic [COLS-1:0] r_red [2][ROWS];
  logic [COLS-1:0] r_grn [2][ROWS];

  logic            r_front_sel;
  logic [RW-1:0]   r_row_idx;
  logic [DW-1:0]   r_dwell_cnt;
  logic [FW-1:0]   r_frame_cnt;
  logic            r_blink_phase;
  logic            r_swap_pending;
  logic            r_swap_done;
  logic            r_frame_start;
  logic [ROWS-1:0] r_row;
  logic [COLS-1:0] r_colr;
  logic [COLS-1:0] r_colg;

  logic            w_dwell_last;
  logic            w_row_last;
  logic            w_boundary;
  logic            w_commit;
  logic            w_blank;
  logic            w_wr_ok;
  logic [ROWS-1:0] w_sel;

  assign w_dwell_last = (r_dwell_cnt == DWELL_LAST);
  assign w_row_last   = (r_row_idx == ROW_LAST);
  assign w_boundary   = en & w_dwell_last & w_row_last;
  assign w_commit     = w_boundary & r_swap_pending;
  assign w_blank      = blink_en & r_blink_phase;
  assign w_wr_ok      = wr_en & ({1'b0, wr_row} < ROWS_W);

  always_comb begin
    w_sel = '0;
    w_sel[r_row_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) begin
        r_red[0][i] <= '0;
        r_red[1][i] <= '0;
        r_grn[0][i] <= '0;
        r_grn[1][i] <= '0;
      end
      r_front_sel    <= 1'b0;
      r_row_idx      <= '0;
      r_dwell_cnt    <= '0;
      r_frame_cnt    <= '0;
      r_blink_phase  <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_done    <= 1'b0;
      r_frame_start  <= 1'b0;
      r_row          <= ROW_IDLE;
      r_colr         <= '0;
      r_colg         <= '0;
    end else begin
      // back buffer is chosen pre-commit, so a commit-cycle write hits the new front
      if (w_wr_ok) begin
        r_red[~r_front_sel][wr_row] <= wr_red;
        r_grn[~r_front_sel][wr_row] <= wr_grn;
      end
      r_swap_done    <= w_commit;
      r_swap_pending <= w_commit ? swap : (r_swap_pending | swap);
      if (w_commit)
        r_front_sel <= ~r_front_sel;

      if (!en) begin
        r_row_idx     <= '0;
        r_dwell_cnt   <= '0;
        r_frame_cnt   <= '0;
        r_frame_start <= 1'b0;
        r_row         <= ROW_IDLE;
        r_colr        <= '0;
        r_colg        <= '0;
      end else begin
        r_row         <= ROW_ACTIVE_LOW ? ~w_sel : w_sel;
        r_colr        <= w_blank ? '0 : r_red[r_front_sel][r_row_idx];
        r_colg        <= w_blank ? '0 : r_grn[r_front_sel][r_row_idx];
        r_frame_start <= (r_row_idx == '0) && (r_dwell_cnt == '0);

        if (w_dwell_last) begin
          r_dwell_cnt <= '0;
          r_row_idx   <= w_row_last ? '0 : r_row_idx + RW'(1);
        end else begin
          r_dwell_cnt <= r_dwell_cnt + DW'(1);
        end

        if (w_boundary) begin
          if (r_frame_cnt == FRAME_LAST) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
          end else begin
            r_frame_cnt <= r_frame_cnt + FW'(1);
          end
        end
      end
    end
  end

  assign row          = r_row;
  assign colr         = r_colr;
  assign colg         = r_colg;
  assign frame_start  = r_frame_start;
  assign swap_done    = r_swap_done;
  assign swap_pending = r_swap_pending;

endmodule
